// File: rtl/div_sequencer.sv
// div_sequencer: iterative RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// A restoring divider on operand magnitudes takes one step per cycle for XLEN cycles.
// A FIX cycle then applies the signs and selects the output. A DONE cycle presents the result.
// Divide-by-zero and signed overflow skip the iteration and go straight to DONE.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, func3        request strobe (sampled only in IDLE) and RV32M func3 (1xx)
//   operand_a/_b        dividend / divisor, latched at the accepting edge
//   flush               synchronous abort; returns to IDLE, result untouched
//   stall               freeze upstream while the request is being worked on
//   busy                registered "not IDLE"
//   valid_out, result   one-cycle completion strobe and held quotient/remainder
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            valid_out,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST    = 6'(XLEN - 1);

    state_e          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;      // partial remainder, one guard bit
    logic [XLEN-1:0] quo_q, quo_d;      // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            sel_rem_q, sel_rem_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic            accept, is_signed, div_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_q, fast_r, q_fix, r_fix;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        accept    = (state_q == IDLE) && start && func3[2] && !flush;
        is_signed = !func3[0];
        a_mag     = (is_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
        b_mag     = (is_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;
        div_zero  = (operand_b == '0);
        ovf       = is_signed && (operand_a == INT_MIN) && (operand_b == '1);
        fast_q    = div_zero ? '1 : INT_MIN;
        fast_r    = div_zero ? operand_a : '0;

        // Restoring step: a borrow out of the guard bit means "does not fit".
        shifted   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        diff      = shifted - {1'b0, dvs_q};

        q_fix     = neg_quo_q ? -quo_q : quo_q;
        r_fix     = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        sel_rem_d = sel_rem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_rem_d = func3[1];
                    cnt_d     = '0;
                    if (div_zero || ovf) begin
                        result_d = func3[1] ? fast_r : fast_q;
                        state_d  = DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        neg_quo_d = is_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                        neg_rem_d = is_signed && operand_a[XLEN-1];
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (!diff[XLEN]) begin
                    rem_d = diff;
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = sel_rem_q ? r_fix : q_fix;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort beats everything; an aborted op never touches result.
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end

        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            sel_rem_q <= sel_rem_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Gated by rst_n so a start held during reset cannot raise stall.
    assign stall     = rst_n && ((state_q == RUN) || (state_q == FIX) || accept);
    assign busy      = busy_q;
    assign valid_out = valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: stimulus pushes {expected result, expected
// valid cycle}; a monitor pops and compares on every valid_out.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] operand_a, operand_b;
    logic        flush;
    logic        stall, busy, valid_out;
    logic [31:0] result;

    div_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func3(func3),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .stall(stall), .busy(busy), .valid_out(valid_out), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid_out must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid: got valid_out=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("valid_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // Drive a request in the next cycle; returns at the negedge of cycle 1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1; func3 = f3; operand_a = a; operand_b = b;
        e.res = exp;
        e.at  = cyc + lat;
        sb.push_back(e);
        #1 chk("stall_at_accept", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; func3 = 3'b100;
        operand_a = 32'd9; operand_b = 32'd3; flush = 1'b0;
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_result", result, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // DIVU 100/7 with stall profile over the run.
        issue(3'b101, 32'd100, 32'd7, 32'd14, 34);
        for (int i = 1; i <= 33; i++) begin
            chk("stall_run", 32'(stall), 32'd1);
            @(negedge clk);
        end
        chk("stall_done", 32'(stall), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
        wait_idle();

        issue(3'b111, 32'd100, 32'd7, 32'd2, 34);                     wait_idle();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);       wait_idle();
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);       wait_idle();
        issue(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);       wait_idle();

        // Fast paths: result in cycle 1.
        issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);                wait_idle();
        issue(3'b111, 32'd5, 32'd0, 32'd5, 1);                        wait_idle();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); wait_idle();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);        wait_idle();

        // Re-pulsed start mid-run is ignored.
        issue(3'b101, 32'd1000, 32'd10, 32'd100, 34);
        repeat (4) @(negedge clk);
        start = 1'b1; func3 = 3'b101; operand_a = 32'd50; operand_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Flush in cycle 10: back to IDLE, no completion, result kept.
        @(negedge clk);
        start = 1'b1; func3 = 3'b101; operand_a = 32'd77; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_result", result, 32'd100);
        issue(3'b101, 32'd77, 32'd7, 32'd11, 34);                     wait_idle();

        // Flush and start together in IDLE: request dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; func3 = 3'b101;
        #1 chk("flush_start_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);

        // Back-to-back: second start in cycle 35.
        issue(3'b101, 32'd1000, 32'd10, 32'd100, 34);
        repeat (33) @(negedge clk);
        issue(3'b101, 32'd81, 32'd9, 32'd9, 34);
        wait_idle();

        // Non-divide func3 is ignored.
        @(negedge clk);
        start = 1'b1; func3 = 3'b000;
        #1 chk("nondiv_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("nondiv_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-run.
        issue(3'b101, 32'd1000, 32'd10, 32'd100, 34);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
